fifo_1w1r_rd_ctrl: RTL and testbench

//  Read-side controller for the dual-clock 1W1R FIFO storage in the XSPI AXI slave datapath.

---
 rtl/fifo_1w1r_rd_ctrl_pkg.sv | 22 ++
 rtl/fifo_1w1r_rd_ctrl_if.sv | 26 ++
 rtl/fifo_1w1r_rd_ctrl_ptr_sync2.sv | 24 ++
 rtl/fifo_1w1r_rd_ctrl.sv | 114 +++++++++++
 tb/tb_fifo_1w1r_rd_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_1w1r_rd_ctrl_pkg.sv
// Shared definitions for the XSPI AXI slave FIFOs: default geometry and Gray-code helpers.
package fifo_1w1r_rd_ctrl_pkg;

  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int FIFO_DATA_WIDTH = 39;
  localparam int GRAY_MAX_W      = 32;

  // Callers zero-extend narrower pointers; leading zeros do not disturb the low bits.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_1w1r_rd_ctrl_if.sv
// Read-side bus of the 1W1R FIFO: memory read port plus the valid/ready output stream.
interface fifo_1w1r_rd_ctrl_if
  import fifo_1w1r_rd_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) ();

  logic [ADDR_WIDTH-1:0] raddr;
  logic                  ren;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output raddr, ren, rd_valid, rd_data,
    input  rdata, rd_ready
  );

  modport slave (
    input  raddr, ren, rd_valid, rd_data,
    output rdata, rd_ready
  );

endinterface

// File: rtl/fifo_1w1r_rd_ctrl_ptr_sync2.sv
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains; shared by both FIFO sides.
module fifo_1w1r_rd_ctrl_ptr_sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  // NOTE: non-blocking assignments keep q1->q a true two-stage shift, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_1w1r_rd_ctrl.sv
// Read-side controller of the dual-clock 1W1R FIFO: pointer sync, empty, fetch and 2-entry prefetch.
// Optional FIFO_RD_LEVEL_EN adds a registered rd_level occupancy output.
module fifo_1w1r_rd_ctrl
  import fifo_1w1r_rd_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDR_WIDTH:0] wptr_gray,
  output logic [ADDR_WIDTH:0] rptr_gray,
  output logic                empty,
`ifdef FIFO_RD_LEVEL_EN
  output logic [ADDR_WIDTH:0] rd_level,
`endif
  fifo_1w1r_rd_ctrl_if.master rd_if
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH:0]   wq2;
  logic [ADDR_WIDTH:0]   rptr_bin;
  logic [ADDR_WIDTH:0]   rptr_bin_nxt;
  logic                  inflight;
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  pop;
  logic                  push;
  logic                  ren;
  logic [2:0]            occ;

  fifo_1w1r_rd_ctrl_ptr_sync2 #(.WIDTH(PW)) u_wptr_sync (
    .clk   (rclk),
    .rst_n (rrst_n),
    .d     (wptr_gray),
    .q     (wq2)
  );

  // Full memory differs from the read pointer in the top two Gray bits, so it reads as non-empty.
  assign empty        = (rptr_gray == wq2);
  assign rd_if.rd_valid = (buf_cnt != 2'd0);
  assign rd_if.rd_data  = head;
  assign pop          = rd_if.rd_valid & rd_if.rd_ready;
  assign push         = inflight;

  // Words already committed to the buffer after this cycle's pop; fetch only while a slot stays free.
  assign occ          = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign ren          = !empty && (occ < 3'd2);
  assign rd_if.ren    = ren;
  assign rd_if.raddr  = rptr_bin[ADDR_WIDTH-1:0];
  assign rptr_bin_nxt = rptr_bin + PW'(1);

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rptr_bin  <= '0;
      rptr_gray <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= ren;
      if (ren) begin
        rptr_bin  <= rptr_bin_nxt;
        rptr_gray <= PW'(bin2gray(GRAY_MAX_W'(rptr_bin_nxt)));
      end
    end
  end

  // NOTE: the two data registers are reset too, so rd_data reads 0 after reset rather than stale data.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      buf_cnt <= 2'd0;
      head    <= '0;
      tail    <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) head <= rd_if.rdata;
          else                 tail <= rd_if.rdata;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          head    <= tail;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd2) begin
            head <= tail;
            tail <= rd_if.rdata;
          end else begin
            head <= rd_if.rdata;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_push_into_full: assert property (
    @(posedge rclk) disable iff (!rrst_n) !(push && !pop && buf_cnt == 2'd2)
  );

`ifdef FIFO_RD_LEVEL_EN
  logic [ADDR_WIDTH:0] wq2_bin;

  assign wq2_bin = PW'(gray2bin(GRAY_MAX_W'(wq2)));

  always_ff @(posedge rclk) begin
    if (!rrst_n) rd_level <= '0;
    else         rd_level <= (wq2_bin - rptr_bin) + PW'(inflight) + PW'(buf_cnt);
  end
`endif

endmodule

// File: tb/tb_fifo_1w1r_rd_ctrl.sv
// Self-checking bench for fifo_1w1r_rd_ctrl: vector table, directed corner sequences, random scoreboard.
`timescale 1ns/1ps
module tb_fifo_1w1r_rd_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 39;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 8;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b0;
  logic [PW-1:0] wptr_gray = 4'b0110;
  logic [PW-1:0] rptr_gray;
  logic          empty;
`ifdef FIFO_RD_LEVEL_EN
  logic [PW-1:0] rd_level;
`endif

  fifo_1w1r_rd_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rd_if ();

  fifo_1w1r_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .wptr_gray (wptr_gray),
    .rptr_gray (rptr_gray),
    .empty     (empty),
`ifdef FIFO_RD_LEVEL_EN
    .rd_level  (rd_level),
`endif
    .rd_if     (rd_if)
  );

  always #5 rclk = ~rclk;

  // Storage array model: registered read, data valid the cycle after ren.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge rclk) begin
    if (rd_if.ren) rd_if.rdata <= mem[rd_if.raddr];
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] to_gray(input int b);
    logic [PW-1:0] x;
    x = PW'(b);
    return x ^ (x >> 1);
  endfunction

  function automatic int from_gray(input logic [PW-1:0] g);
    for (int v = 0; v < 16; v++) if (to_gray(v) == g) return v;
    return 0;
  endfunction

  // Write-side model: binary write count modulo 2*DEPTH, published as Gray.
  int wr_cnt = 0;

  task automatic write_word(input logic [DW-1:0] w);
    mem[wr_cnt % DEPTH] = w;
    wr_cnt = (wr_cnt + 1) % 16;
    wptr_gray = to_gray(wr_cnt);
  endtask

  task automatic do_reset();
    @(posedge rclk); #1;
    rrst_n = 1'b0;
    wr_cnt = 0;
    wptr_gray = '0;
    rd_if.rd_ready = 1'b0;
    @(posedge rclk); #1;
    rrst_n = 1'b1;
  endtask

  // Reference model: expected words in write order; the DUT may hold at most 2 of them.
  logic [DW-1:0] exp_q[$];
  int            raddr_q[$];
  int            fetched = 0;
  int            popped  = 0;
  bit            mon_en  = 1'b0;
  bit            hold_prev = 1'b0;
  logic [DW-1:0] held_data;

  initial begin
    forever begin
      @(negedge rclk);
      if (mon_en) begin
        check("fetch_ahead_le2", 64'((fetched - popped) <= 2), 64'd1);
        if (hold_prev) check("hold_while_stalled", {rd_if.rd_valid, rd_if.rd_data}, {1'b1, held_data});
        if (rd_if.ren) begin
          raddr_q.push_back(int'(rd_if.raddr));
          fetched++;
        end
        if (rd_if.rd_valid && rd_if.rd_ready) begin
          if (exp_q.size() == 0) check("pop_without_word", 64'd1, 64'd0);
          else                   check("pop_data", rd_if.rd_data, exp_q.pop_front());
          popped++;
        end
        hold_prev = rd_if.rd_valid && !rd_if.rd_ready;
        held_data = rd_if.rd_data;
      end
    end
  end

  task automatic stream(input int n, input bit bursty, input int rdy_pct);
    int sent = 0;
    int cyc  = 0;
    bit wr_on = 1'b1;
    logic [DW-1:0] w;
    exp_q.delete();
    raddr_q.delete();
    fetched = 0;
    popped = 0;
    hold_prev = 1'b0;
    mon_en = 1'b1;
    while (popped < n && cyc < 20*n + 100) begin
      @(posedge rclk); #1;
      if (bursty && $urandom_range(0, 99) < 15) wr_on = !wr_on;
      if (sent < n && wr_on && ((wr_cnt - from_gray(rptr_gray) + 16) % 16) < DEPTH) begin
        w = {7'($urandom_range(0, 127)), 32'($urandom)};
        exp_q.push_back(w);
        write_word(w);
        sent++;
      end
      rd_if.rd_ready = ($urandom_range(0, 99) < rdy_pct);
      cyc++;
    end
    check("stream_all_popped", 64'(popped), 64'(n));
    rd_if.rd_ready = 1'b0;
    @(negedge rclk);
    @(negedge rclk);
    mon_en = 1'b0;
    check("stream_drained_valid", {63'd0, rd_if.rd_valid}, 64'd0);
    check("stream_drained_empty", {63'd0, empty}, 64'd1);
  endtask

  typedef struct {
    logic          rdy;
    logic          ren;
    logic [AW-1:0] raddr;
    logic          valid;
    logic          empty;
    logic [PW-1:0] rptr_g;
    logic [DW-1:0] data;
  } vec_t;

  vec_t          vecs [6];
  logic [DW-1:0] words [8];
  int            nren;
  bit            seen;

  initial begin
    rd_if.rd_ready = 1'b0;
    rd_if.rdata    = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // Reset held with a nonzero write pointer present.
    for (int c = 0; c < 3; c++) begin
      @(negedge rclk);
      check("rst_valid", {63'd0, rd_if.rd_valid}, 64'd0);
      check("rst_ren",   {63'd0, rd_if.ren},      64'd0);
      check("rst_empty", {63'd0, empty},          64'd1);
      check("rst_rptr",  64'(rptr_gray),          64'd0);
    end
    check("rst_rd_data", 64'(rd_if.rd_data), 64'd0);
    @(posedge rclk); #1;
    rrst_n = 1'b1;
    wptr_gray = '0;
    @(negedge rclk);
    check("post_rst_valid", {63'd0, rd_if.rd_valid}, 64'd0);
    check("post_rst_ren",   {63'd0, rd_if.ren},      64'd0);
    check("post_rst_empty", {63'd0, empty},          64'd1);
    check("post_rst_rptr",  64'(rptr_gray),          64'd0);

    // Single word: cycle-by-cycle vector table starting right after the write-pointer change.
    vecs[0] = '{rdy: 0, ren: 0, raddr: 0, valid: 0, empty: 1, rptr_g: 0, data: 0};
    vecs[1] = '{rdy: 0, ren: 0, raddr: 0, valid: 0, empty: 1, rptr_g: 0, data: 0};
    vecs[2] = '{rdy: 0, ren: 1, raddr: 0, valid: 0, empty: 0, rptr_g: 0, data: 0};
    vecs[3] = '{rdy: 0, ren: 0, raddr: 0, valid: 0, empty: 1, rptr_g: 1, data: 0};
    vecs[4] = '{rdy: 1, ren: 0, raddr: 0, valid: 1, empty: 1, rptr_g: 1, data: 39'h12345};
    vecs[5] = '{rdy: 0, ren: 0, raddr: 0, valid: 0, empty: 1, rptr_g: 1, data: 0};
    @(posedge rclk); #1;
    write_word(39'h12345);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(posedge rclk); #1;
      end
      rd_if.rd_ready = vecs[k].rdy;
      @(negedge rclk);
      check($sformatf("single_ren_c%0d", k),   {63'd0, rd_if.ren},      {63'd0, vecs[k].ren});
      check($sformatf("single_valid_c%0d", k), {63'd0, rd_if.rd_valid}, {63'd0, vecs[k].valid});
      check($sformatf("single_empty_c%0d", k), {63'd0, empty},          {63'd0, vecs[k].empty});
      check($sformatf("single_rptr_c%0d", k),  64'(rptr_gray),          64'(vecs[k].rptr_g));
      if (vecs[k].ren)   check($sformatf("single_raddr_c%0d", k), 64'(rd_if.raddr),   64'(vecs[k].raddr));
      if (vecs[k].valid) check($sformatf("single_data_c%0d", k),  64'(rd_if.rd_data), 64'(vecs[k].data));
    end
    rd_if.rd_ready = 1'b0;

    // Backpressure: 8 words available, consumer stalled, then drained one per cycle.
    do_reset();
    @(posedge rclk); #1;
    for (int i = 0; i < 8; i++) begin
      words[i] = 39'h5A_0000_0000 | 39'(i * 16'h1111);
      write_word(words[i]);
    end
    nren = 0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge rclk);
      if (rd_if.ren) begin
        check("bp_raddr", 64'(rd_if.raddr), 64'(nren));
        nren++;
      end
      if (seen) check("bp_hold", {rd_if.rd_valid, rd_if.rd_data}, {1'b1, words[0]});
      if (rd_if.rd_valid) seen = 1'b1;
    end
    check("bp_ren_count", 64'(nren), 64'd2);
    check("bp_valid", {63'd0, rd_if.rd_valid}, 64'd1);
`ifdef FIFO_RD_LEVEL_EN
    check("bp_rd_level", 64'(rd_level), 64'd8);
`endif
    @(posedge rclk); #1;
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge rclk);
      check($sformatf("drain_valid_%0d", i), {63'd0, rd_if.rd_valid}, 64'd1);
      check($sformatf("drain_data_%0d", i),  64'(rd_if.rd_data),      64'(words[i]));
    end
    @(negedge rclk);
    check("drain_done_valid", {63'd0, rd_if.rd_valid}, 64'd0);
    check("drain_done_empty", {63'd0, empty},          64'd1);
    rd_if.rd_ready = 1'b0;

    // Wrap: 20 words at full rate; addresses wrap twice, pointer ends at Gray of 4.
    do_reset();
    stream(20, 1'b0, 100);
    check("wrap_fetch_count", 64'(raddr_q.size()), 64'd20);
    for (int i = 0; i < raddr_q.size(); i++) check($sformatf("wrap_raddr_%0d", i), 64'(raddr_q[i]), 64'(i % DEPTH));
    check("wrap_rptr_gray", 64'(rptr_gray), 64'b0110);

    // Random bursts and 50% consumer readiness.
    do_reset();
    stream(1000, 1'b1, 50);

    // Reset with one word buffered and one read in flight.
    do_reset();
    @(posedge rclk); #1;
    for (int i = 0; i < 8; i++) write_word(words[i]);
    repeat (4) @(posedge rclk);
    #1;
    rrst_n = 1'b0;
    wr_cnt = 0;
    wptr_gray = '0;
    @(negedge rclk);
    check("pre_reset_valid", {63'd0, rd_if.rd_valid}, 64'd1);
    @(posedge rclk); #1;
    rrst_n = 1'b1;
    @(negedge rclk);
    check("midrst_valid", {63'd0, rd_if.rd_valid}, 64'd0);
    check("midrst_rptr",  64'(rptr_gray),          64'd0);
    check("midrst_empty", {63'd0, empty},          64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge rclk);
      check("midrst_no_capture", {63'd0, rd_if.rd_valid}, 64'd0);
    end
    @(posedge rclk); #1;
    write_word(39'h7_0000_BEEF);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge rclk);
      if (rd_if.rd_valid) seen = 1'b1;
    end
    check("midrst_refetch_valid", {63'd0, seen}, 64'd1);
    check("midrst_refetch_data", 64'(rd_if.rd_data), 64'(39'h7_0000_BEEF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
